row_shift_engine: RTL and testbench



---
 rtl/led_matrix_pkg.sv | 31 +++
 rtl/row_shift_engine_phase_timer.sv | 32 +++
 rtl/row_shift_engine.sv | 158 +++++++++++++++
 tb/tb_row_shift_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the RGB LED matrix driver blocks.
//   rgb_t         one panel lane (R,G,B)
//   row_state_e   row shift engine state encoding
//   DEF_*         default panel geometry / timing
//   max3()        constant helper for sizing counters
package led_matrix_pkg;

    typedef logic [2:0] rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCLK_LO,
        SCLK_HI,
        LATCH,
        DONE
    } row_state_e;

    localparam int DEF_COLS         = 32;
    localparam int DEF_SCLK_DIV     = 2;
    localparam int DEF_LATCH_CYCLES = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/row_shift_engine_phase_timer.sv
// phase_timer: loadable down-counter with a zero flag. Used by the row
// shift engine to time FETCH, SCLK half-periods and LATCH.
//   clk       system clock
//   reset_n   asynchronous active-low reset (count -> 0)
//   load      load load_val this cycle (has priority over counting)
//   load_val  value to load; the phase then lasts load_val+1 cycles
//   zero      high while the count is zero
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/row_shift_engine.sv
// row_shift_engine: shifts one row of pixel data into the LED panel shift
// registers over CHANNELS parallel lanes, fetching each column from a
// frame-buffer read port, then strobes LATCH with the outputs blanked and
// reports completion.
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   start     begin a row (sampled only in IDLE)
//   abort     synchronous abort back to IDLE, no latch pulse
//   col_addr  frame-buffer column address (registered)
//   rgb_in    frame-buffer pixel data, lane k = bits [3k+2:3k]
//   rgb_out   panel data pins (registered)
//   sclk      panel shift clock
//   latch     panel latch strobe
//   oe_n      panel output enable, active-low (high only during LATCH)
//   busy      high in every state except IDLE
//   done      one-cycle pulse after the latch completes
module row_shift_engine
    import led_matrix_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int CHANNELS     = 2,
    parameter int SCLK_DIV     = DEF_SCLK_DIV,
    parameter int RD_LAT       = 1,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [$clog2(COLS)-1:0] col_addr,
    input  logic [3*CHANNELS-1:0]   rgb_in,
    output logic [3*CHANNELS-1:0]   rgb_out,
    output logic                    sclk,
    output logic                    latch,
    output logic                    oe_n,
    output logic                    busy,
    output logic                    done
);

    localparam int AW     = $clog2(COLS);
    localparam int PH_MAX = max3(SCLK_DIV, LATCH_CYCLES, RD_LAT + 1);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    // Timer load values: a phase lasts load value + 1 cycles.
    localparam logic [PH_W-1:0] FETCH_LD = PH_W'(RD_LAT);
    localparam logic [PH_W-1:0] SCLK_LD  = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0] LATCH_LD = PH_W'(LATCH_CYCLES - 1);
    localparam logic [AW-1:0]   LAST_COL = AW'(COLS - 1);

    row_state_e      state, state_n;
    logic [AW-1:0]   col_n;
    logic            capture;
    logic            ph_load;
    logic [PH_W-1:0] ph_val;
    logic            ph_zero;

    phase_timer #(
        .W (PH_W)
    ) u_phase (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ph_load),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    always_comb begin
        state_n = state;
        col_n   = col_addr;
        capture = 1'b0;
        ph_load = 1'b0;
        ph_val  = '0;

        if (abort) begin
            // abort overrides start and any phase timing
            state_n = IDLE;
            col_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_n = FETCH;
                        col_n   = '0;
                        ph_load = 1'b1;
                        ph_val  = FETCH_LD;
                    end
                end
                FETCH: begin
                    if (ph_zero) begin
                        // read data is valid on the edge that ends FETCH
                        state_n = SCLK_LO;
                        capture = 1'b1;
                        ph_load = 1'b1;
                        ph_val  = SCLK_LD;
                    end
                end
                SCLK_LO: begin
                    if (ph_zero) begin
                        state_n = SCLK_HI;
                        ph_load = 1'b1;
                        ph_val  = SCLK_LD;
                    end
                end
                SCLK_HI: begin
                    if (ph_zero) begin
                        ph_load = 1'b1;
                        if (col_addr == LAST_COL) begin
                            state_n = LATCH;
                            ph_val  = LATCH_LD;
                        end else begin
                            state_n = FETCH;
                            col_n   = col_addr + AW'(1);
                            ph_val  = FETCH_LD;
                        end
                    end
                end
                LATCH: begin
                    if (ph_zero) begin
                        state_n = DONE;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered copies of what the next state implies, so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            col_addr <= '0;
            rgb_out  <= '0;
            sclk     <= 1'b0;
            latch    <= 1'b0;
            oe_n     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            col_addr <= col_n;
            if (capture) begin
                rgb_out <= rgb_in;
            end
            sclk     <= (state_n == SCLK_HI);
            latch    <= (state_n == LATCH);
            oe_n     <= (state_n == LATCH);
            busy     <= (state_n != IDLE);
            done     <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_row_shift_engine.sv
// Testbench for row_shift_engine: a default-geometry instance fed by a
// 1-cycle-latency frame-buffer model and a small 4-column instance fed by a
// zero-latency one. Expected shifted data, edge counts, spacing and timing
// are derived from frame-buffer contents and the row timing formula.
module tb_row_shift_engine;
    import led_matrix_pkg::*;

    localparam int A_COLS = 32, A_CH = 2, A_DIV = 2, A_LAT = 1, A_LC = 4;
    localparam int B_COLS = 4,  B_CH = 3, B_DIV = 1, B_LAT = 0, B_LC = 4;
    localparam int A_T = A_COLS * (A_LAT + 1 + 2 * A_DIV) + A_LC + 1;
    localparam int B_T = B_COLS * (B_LAT + 1 + 2 * B_DIV) + B_LC + 1;
    localparam int B_PERIOD = B_LAT + 1 + 2 * B_DIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // ---------------- instance A (defaults) ----------------
    logic       a_start, a_abort;
    logic [4:0] a_col;
    logic [5:0] a_rgb_in, a_rgb_out, a_rd;
    logic       a_sclk, a_latch, a_oe_n, a_busy, a_done;
    logic [5:0] fb_a [A_COLS];

    always @(posedge clk) a_rd <= fb_a[a_col];
    assign a_rgb_in = a_rd;

    row_shift_engine #(
        .COLS(A_COLS), .CHANNELS(A_CH), .SCLK_DIV(A_DIV),
        .RD_LAT(A_LAT), .LATCH_CYCLES(A_LC)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort),
        .col_addr(a_col), .rgb_in(a_rgb_in), .rgb_out(a_rgb_out),
        .sclk(a_sclk), .latch(a_latch), .oe_n(a_oe_n),
        .busy(a_busy), .done(a_done)
    );

    // ---------------- instance B (small, zero latency) ----------------
    logic       b_start, b_abort;
    logic [1:0] b_col;
    logic [8:0] b_rgb_in, b_rgb_out;
    logic       b_sclk, b_latch, b_oe_n, b_busy, b_done;
    logic [8:0] fb_b [B_COLS];

    assign b_rgb_in = fb_b[b_col];

    row_shift_engine #(
        .COLS(B_COLS), .CHANNELS(B_CH), .SCLK_DIV(B_DIV),
        .RD_LAT(B_LAT), .LATCH_CYCLES(B_LC)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
        .col_addr(b_col), .rgb_in(b_rgb_in), .rgb_out(b_rgb_out),
        .sclk(b_sclk), .latch(b_latch), .oe_n(b_oe_n),
        .busy(b_busy), .done(b_done)
    );

    // ---------------- monitors (sole writers of their state) ----------------
    logic        a_prev_sclk = 1'b0;
    logic [5:0]  a_q [$];
    int unsigned a_latch_cnt = 0, a_oe_bad = 0, a_done_cnt = 0, a_done_cyc = 0;

    always @(negedge clk) begin
        a_prev_sclk <= a_sclk;
        if (a_sclk && !a_prev_sclk) a_q.push_back(a_rgb_out);
        if (a_latch) a_latch_cnt <= a_latch_cnt + 1;
        if (a_latch !== a_oe_n) a_oe_bad <= a_oe_bad + 1;
        if (a_done) begin
            a_done_cnt <= a_done_cnt + 1;
            a_done_cyc <= cyc;
        end
    end

    logic        b_prev_sclk = 1'b0;
    logic [8:0]  b_q [$];
    int unsigned b_ecyc [$];
    int unsigned b_latch_cnt = 0, b_oe_bad = 0, b_done_cnt = 0, b_done_cyc = 0;

    always @(negedge clk) begin
        b_prev_sclk <= b_sclk;
        if (b_sclk && !b_prev_sclk) begin
            b_q.push_back(b_rgb_out);
            b_ecyc.push_back(cyc);
        end
        if (b_latch) b_latch_cnt <= b_latch_cnt + 1;
        if (b_latch !== b_oe_n) b_oe_bad <= b_oe_bad + 1;
        if (b_done) begin
            b_done_cnt <= b_done_cnt + 1;
            b_done_cyc <= cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_row_a(input string tag, input int unsigned inject_at);
        int unsigned base, l0, d0, o0, e;
        bit seen;
        base = a_q.size(); l0 = a_latch_cnt; d0 = a_done_cnt; o0 = a_oe_bad;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        e = cyc;
        seen = 1'b0;
        for (int i = 0; i < A_T + 50 && !seen; i++) begin
            a_start = (inject_at != 0 && cyc == e + inject_at - 1);
            tick();
            if (a_done_cnt != d0) seen = 1'b1;
        end
        a_start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_cycle"}, a_done_cyc - e + 1, A_T);
        check({tag, "_busy_in_done"}, 32'(a_busy), 32'd1);
        tick();
        check({tag, "_busy_after"}, 32'({a_busy, a_done}), 32'd0);
        check({tag, "_edges"}, a_q.size() - base, A_COLS);
        for (int n = 0; n < A_COLS; n++)
            if (base + n < a_q.size())
                check($sformatf("%s_col%0d", tag, n), 32'(a_q[base + n]), 32'(fb_a[n]));
        check({tag, "_latch_len"}, a_latch_cnt - l0, A_LC);
        check({tag, "_oe_vs_latch"}, a_oe_bad - o0, 0);
        check({tag, "_done_pulses"}, a_done_cnt - d0, 1);
    endtask

    task automatic run_row_b(input string tag);
        int unsigned base, l0, d0, o0, e;
        bit seen;
        base = b_q.size(); l0 = b_latch_cnt; d0 = b_done_cnt; o0 = b_oe_bad;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        e = cyc;
        seen = 1'b0;
        for (int i = 0; i < B_T + 50 && !seen; i++) begin
            tick();
            if (b_done_cnt != d0) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_cycle"}, b_done_cyc - e + 1, B_T);
        tick();
        check({tag, "_busy_after"}, 32'(b_busy), 32'd0);
        check({tag, "_edges"}, b_q.size() - base, B_COLS);
        for (int n = 0; n < B_COLS; n++)
            if (base + n < b_q.size())
                check($sformatf("%s_col%0d", tag, n), 32'(b_q[base + n]), 32'(fb_b[n]));
        for (int n = 1; n < B_COLS; n++)
            if (base + n < b_ecyc.size())
                check($sformatf("%s_gap%0d", tag, n),
                      b_ecyc[base + n] - b_ecyc[base + n - 1], B_PERIOD);
        check({tag, "_latch_len"}, b_latch_cnt - l0, B_LC);
        check({tag, "_oe_vs_latch"}, b_oe_bad - o0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int unsigned base, l0, d0, e;
        logic [5:0] held;
        bit reached;
        rgb_t c3;

        a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
        for (int n = 0; n < A_COLS; n++) begin
            c3 = rgb_t'(n);
            fb_a[n] = {c3, ~c3};
        end
        for (int n = 0; n < B_COLS; n++) fb_b[n] = 9'($urandom);

        // reset state
        repeat (3) tick();
        check("reset_a", 32'({a_col, a_rgb_out, a_sclk, a_latch, a_oe_n, a_busy, a_done}), 32'd0);
        check("reset_b", 32'({b_col, b_rgb_out, b_sclk, b_latch, b_oe_n, b_busy, b_done}), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // column pattern row on the default instance
        run_row_a("row_pat", 0);

        // small instance, random data
        run_row_b("row_b0");
        for (int n = 0; n < B_COLS; n++) fb_b[n] = 9'($urandom);
        run_row_b("row_b1");

        // start while busy is ignored; a start 2 cycles after done runs normally
        for (int n = 0; n < A_COLS; n++) fb_a[n] = 6'($urandom);
        run_row_a("row_busy_start", 50);
        tick();
        for (int n = 0; n < A_COLS; n++) fb_a[n] = 6'($urandom);
        run_row_a("row_second", 0);

        // abort mid SCLK_HI
        for (int n = 0; n < A_COLS; n++) fb_a[n] = 6'($urandom);
        base = a_q.size(); l0 = a_latch_cnt; d0 = a_done_cnt;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        e = cyc;
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            if (cyc >= e + 99 && a_sclk) reached = 1'b1;
            else tick();
        end
        check("abort_reached_sclk_hi", 32'(reached), 32'd1);
        held = (a_q.size() > base) ? fb_a[a_q.size() - base - 1] : 6'd0;
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("abort_outputs", 32'({a_col, a_sclk, a_latch, a_oe_n, a_busy, a_done}), 32'd0);
        check("abort_rgb_hold", 32'(a_rgb_out), 32'(held));
        repeat (250) tick();
        check("abort_no_latch", a_latch_cnt - l0, 0);
        check("abort_no_done", a_done_cnt - d0, 0);
        check("abort_idle", 32'(a_busy), 32'd0);
        run_row_a("row_post_abort", 0);

        // asynchronous reset pulse mid-row
        for (int n = 0; n < A_COLS; n++) fb_a[n] = 6'($urandom);
        d0 = a_done_cnt;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (60) tick();
        reset_n = 1'b0;
        #1;
        check("async_reset_a",
              32'({a_col, a_rgb_out, a_sclk, a_latch, a_oe_n, a_busy, a_done}), 32'd0);
        #2;
        reset_n = 1'b1;
        base = a_q.size();
        repeat (50) tick();
        check("reset_stays_idle", 32'(a_busy), 32'd0);
        check("reset_no_edges", a_q.size() - base, 0);
        check("reset_no_done", a_done_cnt - d0, 0);
        run_row_a("row_post_reset", 0);

        // start and abort together in IDLE
        base = a_q.size();
        a_start = 1'b1;
        a_abort = 1'b1;
        tick();
        a_start = 1'b0;
        a_abort = 1'b0;
        check("start_abort_idle", 32'({a_busy, a_sclk}), 32'd0);
        repeat (5) tick();
        check("start_abort_still_idle", 32'(a_busy), 32'd0);
        check("start_abort_no_edges", a_q.size() - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
